// File: rtl/sdram_arbit.sv
// sdram_arbit: grants the single SDRAM command bus to one of the init,
// auto-refresh, write and read sub-controllers. It also generates the
// periodic refresh request and muxes the granted controller onto the pins.
module sdram_arbit #(
    parameter int REF_CYC = 750,
    parameter int REF_W   = 10,
    parameter int WR_MAX  = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,
    input  logic        wr_dq_oe,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic        aref_end,
    input  logic        wr_end,
    input  logic        rd_end,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic        sdram_dq_oe,
    output logic        ref_miss
);

    localparam int STK_W = $clog2(WR_MAX + 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_CYC - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(WR_MAX);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              aref_en_q, aref_en_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [REF_W-1:0]  timer_q, timer_d;
    logic              aref_pend_q, aref_pend_d;
    logic [STK_W-1:0]  wr_streak_q, wr_streak_d;
    logic              ref_miss_q, ref_miss_d;
    logic              grant_aref_s;
    logic              timer_run_s;
    logic              timer_hit_s;

    // Arbitration: next state, grants and write-streak bookkeeping.
    always_comb begin
        state_d      = state_q;
        aref_en_d    = aref_en_q;
        wr_en_d      = wr_en_q;
        rd_en_d      = rd_en_q;
        wr_streak_d  = wr_streak_q;
        grant_aref_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_end) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (aref_pend_q) begin
                    state_d      = ST_AREF;
                    aref_en_d    = 1'b1;
                    grant_aref_s = 1'b1;
                end else if (rd_req && (wr_streak_q == STK_MAX)) begin
                    // Reads starved long enough: force one through.
                    state_d     = ST_READ;
                    rd_en_d     = 1'b1;
                    wr_streak_d = '0;
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                    if (!rd_req) begin
                        wr_streak_d = '0;
                    end else if (wr_streak_q == STK_MAX) begin
                        wr_streak_d = wr_streak_q;
                    end else begin
                        wr_streak_d = wr_streak_q + STK_W'(1);
                    end
                end else if (rd_req) begin
                    state_d     = ST_READ;
                    rd_en_d     = 1'b1;
                    wr_streak_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AREF: begin
                if (aref_end) begin
                    state_d   = ST_IDLE;
                    aref_en_d = 1'b0;
                end else begin
                    state_d = ST_AREF;
                end
            end
            ST_WRITE: begin
                if (wr_end) begin
                    state_d = ST_IDLE;
                    wr_en_d = 1'b0;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (rd_end) begin
                    state_d = ST_IDLE;
                    rd_en_d = 1'b0;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d   = ST_INIT;
                aref_en_d = 1'b0;
                wr_en_d   = 1'b0;
                rd_en_d   = 1'b0;
            end
        endcase
    end

    // Refresh timer, pending-refresh flag and sticky overrun flag.
    always_comb begin
        timer_run_s = (state_q != ST_INIT);
        timer_hit_s = timer_run_s && (timer_q == REF_LAST);
        if (!timer_run_s) begin
            timer_d = timer_q;
        end else if (timer_hit_s) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + REF_W'(1);
        end
        // A new request wins over a same-edge grant so it is never lost.
        if (timer_hit_s) begin
            aref_pend_d = 1'b1;
        end else if (grant_aref_s) begin
            aref_pend_d = 1'b0;
        end else begin
            aref_pend_d = aref_pend_q;
        end
        ref_miss_d = ref_miss_q | (timer_hit_s & aref_pend_q);
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_INIT;
            aref_en_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            timer_q     <= '0;
            aref_pend_q <= 1'b0;
            wr_streak_q <= '0;
            ref_miss_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            aref_en_q   <= aref_en_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            timer_q     <= timer_d;
            aref_pend_q <= aref_pend_d;
            wr_streak_q <= wr_streak_d;
            ref_miss_q  <= ref_miss_d;
        end
    end

    // Bus mux: the owner of the current state drives the SDRAM pins.
    always_comb begin
        sdram_dq_oe = 1'b0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd   = wr_cmd;
                sdram_ba    = wr_ba;
                sdram_addr  = wr_addr;
                sdram_dq_oe = wr_dq_oe;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = 4'b0111;
                sdram_ba   = 2'b11;
                sdram_addr = 13'h1fff;
            end
        endcase
    end

    assign aref_en  = aref_en_q;
    assign wr_en    = wr_en_q;
    assign rd_en    = rd_en_q;
    assign ref_miss = ref_miss_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: a vector table for single-cycle arbitration
// steps, plus hand-written sequences for refresh timing, refresh deferral
// during a write, refresh overrun and reset in the middle of a burst.
module tb_sdram_arbit;

    localparam int S_INIT  = 0;
    localparam int S_IDLE  = 1;
    localparam int S_AREF  = 2;
    localparam int S_WRITE = 3;
    localparam int S_READ  = 4;

    localparam logic [3:0]  INIT_CMD  = 4'h1;
    localparam logic [1:0]  INIT_BA   = 2'd0;
    localparam logic [12:0] INIT_ADDR = 13'h0001;
    localparam logic [3:0]  AREF_CMD  = 4'h2;
    localparam logic [1:0]  AREF_BA   = 2'd1;
    localparam logic [12:0] AREF_ADDR = 13'h0002;
    localparam logic [3:0]  WR_CMD    = 4'h4;
    localparam logic [1:0]  WR_BA     = 2'd2;
    localparam logic [12:0] WR_ADDR   = 13'h0444;
    localparam logic [3:0]  RD_CMD    = 4'h5;
    localparam logic [1:0]  RD_BA     = 2'd3;
    localparam logic [12:0] RD_ADDR   = 13'h0555;

    logic        sys_clk = 1'b0;
    logic        sys_rst, init_end, wr_dq_oe;
    logic        wr_req, rd_req, aref_end, wr_end, rd_end;
    logic        aref_en, wr_en, rd_en, sdram_dq_oe, ref_miss;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       wr_req;
        logic       rd_req;
        logic       wr_end;
        logic       rd_end;
        logic       aref_end;
        logic [2:0] exp_st;
    } vec_t;

    vec_t vecs[$];

    sdram_arbit #(.REF_CYC(750), .REF_W(10), .WR_MAX(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
        .init_cmd(INIT_CMD), .init_ba(INIT_BA), .init_addr(INIT_ADDR),
        .aref_cmd(AREF_CMD), .aref_ba(AREF_BA), .aref_addr(AREF_ADDR),
        .wr_cmd(WR_CMD), .wr_ba(WR_BA), .wr_addr(WR_ADDR),
        .rd_cmd(RD_CMD), .rd_ba(RD_BA), .rd_addr(RD_ADDR),
        .wr_dq_oe(wr_dq_oe), .wr_req(wr_req), .rd_req(rd_req),
        .aref_end(aref_end), .wr_end(wr_end), .rd_end(rd_end),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_oe(sdram_dq_oe), .ref_miss(ref_miss)
    );

    always #5 sys_clk = ~sys_clk;

    // Expected {wr_en, rd_en, aref_en, dq_oe, cmd, ba, addr} for a state.
    function automatic logic [22:0] exp_vec(input int st);
        case (st)
            S_INIT:  return {4'b0000, INIT_CMD, INIT_BA, INIT_ADDR};
            S_AREF:  return {4'b0010, AREF_CMD, AREF_BA, AREF_ADDR};
            S_WRITE: return {4'b1001, WR_CMD, WR_BA, WR_ADDR};
            S_READ:  return {4'b0100, RD_CMD, RD_BA, RD_ADDR};
            default: return {4'b0000, 4'b0111, 2'b11, 13'h1fff};
        endcase
    endfunction

    function automatic logic [22:0] obs();
        return {wr_en, rd_en, aref_en, sdram_dq_oe, sdram_cmd, sdram_ba, sdram_addr};
    endfunction

    function automatic vec_t mk(input logic w, input logic r, input logic we,
                                input logic re, input logic ae, input int st);
        vec_t v;
        v.wr_req = w; v.rd_req = r; v.wr_end = we; v.rd_end = re; v.aref_end = ae;
        v.exp_st = 3'(st);
        return v;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_bus(input string name, input int st);
        logic [22:0] a;
        logic [22:0] e;
        a = obs();
        e = exp_vec(st);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_in();
        wr_req = 1'b0; rd_req = 1'b0;
        wr_end = 1'b0; rd_end = 1'b0; aref_end = 1'b0;
    endtask

    initial begin
        int cnt;
        int bad;
        sys_rst = 1'b1; init_end = 1'b0; wr_dq_oe = 1'b1;
        clr_in();

        // Reset and init handshake
        step();
        sys_rst = 1'b0;
        chk_bus("reset_bus", S_INIT);
        chk_int("reset_ref_miss", int'(ref_miss), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs() !== exp_vec(S_INIT)) bad++;
        end
        chk_int("init_hold", bad, 0);
        init_end = 1'b1;
        step();
        init_end = 1'b0;
        chk_bus("init_to_idle", S_IDLE);

        // Arbitration vector table
        vecs.push_back(mk(1, 0, 0, 0, 0, S_WRITE));
        vecs.push_back(mk(0, 0, 0, 1, 0, S_WRITE));
        vecs.push_back(mk(0, 0, 1, 0, 0, S_IDLE));
        vecs.push_back(mk(0, 1, 0, 0, 0, S_READ));
        vecs.push_back(mk(0, 0, 1, 0, 0, S_READ));
        vecs.push_back(mk(0, 0, 0, 0, 1, S_READ));
        vecs.push_back(mk(0, 0, 0, 1, 0, S_IDLE));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(1, 1, 0, 0, 0, S_WRITE));
            vecs.push_back(mk(1, 1, 1, 0, 0, S_IDLE));
        end
        vecs.push_back(mk(1, 1, 0, 0, 0, S_READ));
        vecs.push_back(mk(1, 1, 0, 1, 0, S_IDLE));
        vecs.push_back(mk(1, 1, 0, 0, 0, S_WRITE));
        vecs.push_back(mk(0, 0, 1, 0, 0, S_IDLE));
        vecs.push_back(mk(0, 0, 0, 0, 0, S_IDLE));
        vecs.push_back(mk(1, 0, 0, 0, 0, S_WRITE));
        vecs.push_back(mk(0, 0, 1, 0, 0, S_IDLE));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(1, 1, 0, 0, 0, S_WRITE));
            vecs.push_back(mk(1, 1, 1, 0, 0, S_IDLE));
        end
        vecs.push_back(mk(1, 1, 0, 0, 0, S_WRITE));
        vecs.push_back(mk(0, 0, 1, 0, 0, S_IDLE));
        vecs.push_back(mk(0, 1, 0, 0, 0, S_READ));
        vecs.push_back(mk(0, 0, 0, 1, 0, S_IDLE));

        foreach (vecs[i]) begin
            wr_req   = vecs[i].wr_req;
            rd_req   = vecs[i].rd_req;
            wr_end   = vecs[i].wr_end;
            rd_end   = vecs[i].rd_end;
            aref_end = vecs[i].aref_end;
            step();
            chk_bus($sformatf("vec%0d", i), int'(vecs[i].exp_st));
        end
        clr_in();

        // Refresh timing from a fresh init
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        init_end = 1'b1;
        step();
        init_end = 1'b0;
        cnt = 0;
        while (!aref_en && cnt < 800) begin
            step();
            cnt++;
        end
        chk_int("aref_first_latency", cnt, 751);
        chk_bus("aref_first_bus", S_AREF);
        for (int i = 0; i < 7; i++) step();
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        chk_bus("aref_end_idle", S_IDLE);
        cnt = 8;
        while (!aref_en && cnt < 800) begin
            step();
            cnt++;
        end
        chk_int("aref_period", cnt, 750);

        // Refresh falling due during a write waits for the next IDLE
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        wr_req = 1'b1;
        step();
        bad = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (wr_en !== 1'b1 || aref_en !== 1'b0) bad++;
        end
        chk_int("no_preempt", bad, 0);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk_bus("wr_end_idle", S_IDLE);
        step();
        chk_bus("aref_before_wr", S_AREF);
        chk_int("ref_miss_clear", int'(ref_miss), 0);

        // Refresh overrun while a write is held, then reset mid-write
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        step();
        chk_bus("long_write", S_WRITE);
        for (int i = 0; i < 800; i++) step();
        chk_int("ref_miss_one_wrap", int'(ref_miss), 0);
        for (int i = 0; i < 800; i++) step();
        chk_int("ref_miss_set", int'(ref_miss), 1);
        chk_bus("still_write", S_WRITE);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk_bus("reset_mid_write", S_INIT);
        chk_int("reset_ref_miss_clr", int'(ref_miss), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
